dcache_fill_fsm: RTL and testbench
==================================

// Module: dcache_fill_fsm
// PURPOSE
//  Miss-handling FSM between the MEM stage and multi-cycle main memory.
//  On a D-cache (or I-cache) miss it stalls the pipeline and fetches the whole block, one word at a time.
//  It writes each returned word into the cache data array, then updates the tag array.
//  The MEM stage treats fsm_busy as a pipeline stall. It resumes when busy drops and the access re-hits.
// PARAMETERS
//  ADDR_W      16  byte-address width
//  DATA_W      16  word width (one word = 2 bytes)
//  WORDS       8   words per block; block = 16 bytes, offset = addr[3:0]
//  CNT_W       3   log2(WORDS), width of issue/receive counters
// PORTS
//  clk                 in   1       clock, all state updates on posedge
//  rst_n               in   1       reset, synchronous, active-low
//  miss_detected       in   1       MEM-stage tag compare missed this cycle
//  miss_address        in   ADDR_W  byte address of missing access
//  fsm_busy            out  1       stall request to pipeline
//  mem_en              out  1       issue read request to memory this cycle
//  memory_address      out  ADDR_W  address of issued request
//  memory_data_valid   in   1       memory returning one word this cycle
//  memory_data         in   DATA_W  returned word
//  write_data_array    out  1       write returned word into cache data array
//  cache_wrt_addr      out  ADDR_W  byte address of word being written
//  cache_wrt_data      out  DATA_W  = memory_data, passed through
//  write_tag_array     out  1       write tag+valid for block (final word cycle)
// BEHAVIOUR
//  States: IDLE, WAIT (one state reg); counters issue_cnt, recv_cnt (CNT_W+1 bits each); base reg.
//  Reset: state=IDLE, counters=0, base=0.
//   Outputs during reset: fsm_busy, mem_en, write_data_array and write_tag_array are 0; memory_address is 0.
//  IDLE:
//   fsm_busy = miss_detected (combinational, so the pipeline stalls in the detect cycle).
//   If miss_detected: base <= {miss_address[15:4],4'h0}; counters <= 0; state <= WAIT.
//   memory_data_valid is ignored in IDLE. No write strobes.
//  WAIT:
//   fsm_busy = 1.
//   Issue: while issue_cnt < WORDS, mem_en = 1 and memory_address = base + 2*issue_cnt.
//    issue_cnt increments every cycle. Requests are pipelined: one per cycle, no backpressure.
//    When issue_cnt == WORDS: mem_en = 0 and memory_address = 0.
//   Receive: when memory_data_valid = 1 and recv_cnt < WORDS:
//    write_data_array = 1 and cache_wrt_addr = base + 2*recv_cnt.
//    recv_cnt increments on that edge.
//   Last word (valid while recv_cnt == WORDS-1):
//    write_tag_array = 1 in the same cycle as the last data write.
//    state <= IDLE, so fsm_busy = 0 in the next cycle.
//   miss_detected is ignored in WAIT. A miss held high after the fill starts a new fill only on a fresh IDLE cycle.
//  Completion depends only on the count of valid strobes, not on a fixed latency.
//   With 4-cycle memory, requests issue in W0..W7, data returns in W4..W11, and tag write happens in W11.
//   fsm_busy is high for 13 cycles (detect cycle + W0..W11).
//  Boundaries:
//   Block address arithmetic never wraps: offset bits are forced to 0.
//    A miss at 0xFFFE fetches 0xFFF0..0xFFFE.
//   Extra valid strobes after recv_cnt == WORDS, or in IDLE, are dropped: no writes.
//   Valid in the same cycle as an issue is legal; both actions occur.
//   Reset mid-fill: next cycle is IDLE with no strobes. In-flight memory returns arrive in IDLE and are ignored.
//   cache_wrt_addr = 0 whenever write_data_array = 0.
// TESTING
//  1 Reset: hold rst_n=0 for 2 edges with miss_detected=1 -> all outputs 0 and state IDLE. After release, detect -> busy.
//  2 Miss at 0x1236, 4-cycle memory returning 0xA000+i ->
//    mem addresses 0x1230..0x123E in W0..W7; data writes to 0x1230..0x123E with 0xA000..0xA007 in W4..W11;
//    write_tag_array only in W11; busy for 13 cycles.
//  3 Miss at 0xFFFE -> requests 0xFFF0..0xFFFE and no wrap to 0x0000. Then a miss at 0x0000 fetches 0x0000..0x000E.
//  4 Irregular valid gaps (memory stalls 3 cycles after word 2) -> exactly 8 writes in order.
//    Tag write coincides with the 8th; busy holds until then.
//  5 rst_n=0 at W5 -> IDLE next cycle. Late valid strobes produce no writes. A new miss at 0x4000 then fills cleanly.
//  6 miss_detected held high through a fill at 0x0020 -> after the tag write, one IDLE cycle with busy=1, then a second fill starts.
//    Spurious valid in IDLE -> no write.

Source files
------------

// File: rtl/dcache_fill_fsm.sv
// Block-fill engine for cache misses: stalls the pipeline, streams one read
// request per cycle to memory and writes returned words into the data array.
module dcache_fill_fsm #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              fsm_busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] memory_address,
    input  logic              memory_data_valid,
    input  logic [DATA_W-1:0] memory_data,
    output logic              write_data_array,
    output logic [ADDR_W-1:0] cache_wrt_addr,
    output logic [DATA_W-1:0] cache_wrt_data,
    output logic              write_tag_array
);

    localparam int              OFF_W   = $clog2(WORDS * DATA_W / 8);
    localparam logic [CNT_W:0]  WORDS_C = (CNT_W + 1)'(WORDS);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state_q;
    logic [CNT_W:0]      issue_cnt_q;
    logic [CNT_W:0]      recv_cnt_q;
    logic [ADDR_W-1:0]   base_q;

    logic                inWait;
    logic                issuing;
    logic                recvOk;
    logic                lastWord;
    logic [ADDR_W-1:0]   issueOffset;
    logic [ADDR_W-1:0]   recvOffset;

    // Outputs decode directly from the registered state so the detect-cycle
    // stall and the in-flight strobes line up with the memory pipeline.
    assign inWait      = rst_n && (state_q == S_WAIT);
    assign issuing     = inWait && (issue_cnt_q < WORDS_C);
    assign recvOk      = inWait && memory_data_valid && (recv_cnt_q < WORDS_C);
    assign lastWord    = recvOk && (recv_cnt_q == WORDS_C - 1'b1);

    assign issueOffset = {{(ADDR_W-CNT_W-1){1'b0}}, issue_cnt_q[CNT_W-1:0], 1'b0};
    assign recvOffset  = {{(ADDR_W-CNT_W-1){1'b0}}, recv_cnt_q[CNT_W-1:0], 1'b0};

    assign fsm_busy         = rst_n && ((state_q == S_WAIT) || miss_detected);
    assign mem_en           = issuing;
    assign memory_address   = issuing ? (base_q + issueOffset) : '0;
    assign write_data_array = recvOk;
    assign cache_wrt_addr   = recvOk ? (base_q + recvOffset) : '0;
    assign cache_wrt_data   = memory_data;
    assign write_tag_array  = lastWord;

    // Base is block-aligned, so base + offset can never carry out of the block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            base_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_detected) begin
                        base_q      <= {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        issue_cnt_q <= '0;
                        recv_cnt_q  <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (issuing) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    if (recvOk) begin
                        recv_cnt_q <= recv_cnt_q + 1'b1;
                    end
                    if (lastWord) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Randomized bench for dcache_fill_fsm, checked cycle by cycle against a
// queue-based model of which block words are still to be requested and written.
module tb_dcache_fill_fsm;

    logic        clk;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        mem_en;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [15:0] cache_wrt_addr;
    logic [15:0] cache_wrt_data;
    logic        write_tag_array;

    int total = 0;
    int bad   = 0;

    // Reference model: addresses still owed to memory and to the data array.
    logic [15:0] reqQ[$];
    logic [15:0] wrQ[$];
    bit          modelFilling = 0;

    int busyCount;
    int writeCount;
    int tagCount;

    dcache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .mem_en            (mem_en),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .cache_wrt_addr    (cache_wrt_addr),
        .cache_wrt_data    (cache_wrt_data),
        .write_tag_array   (write_tag_array)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check before posedge, advance model after it.
    task automatic applyStimulus(input logic miss, input logic [15:0] addr, input logic valid,
                                 input logic [15:0] data, input logic rstn);
        logic        expBusy, expEn, expWr, expTag;
        logic [15:0] expMemAddr, expWrAddr, blk;
        @(negedge clk);
        rst_n             = rstn;
        miss_detected     = miss;
        miss_address      = addr;
        memory_data_valid = valid;
        memory_data       = data;
        #1;
        expBusy = 0; expEn = 0; expWr = 0; expTag = 0;
        expMemAddr = '0; expWrAddr = '0;
        if (rstn) begin
            if (!modelFilling) begin
                expBusy = miss;
            end else begin
                expBusy    = 1;
                expEn      = (reqQ.size() != 0);
                expMemAddr = expEn ? reqQ[0] : 16'h0;
                expWr      = valid && (wrQ.size() != 0);
                expWrAddr  = expWr ? wrQ[0] : 16'h0;
                expTag     = expWr && (wrQ.size() == 1);
            end
        end
        checkOutput("busy",     fsm_busy,         expBusy);
        checkOutput("memEn",    mem_en,           expEn);
        checkOutput("memAddr",  memory_address,   expMemAddr);
        checkOutput("wrData",   write_data_array, expWr);
        checkOutput("wrAddr",   cache_wrt_addr,   expWrAddr);
        checkOutput("tagWr",    write_tag_array,  expTag);
        if (expWr) checkOutput("wrtData", cache_wrt_data, data);
        busyCount  += fsm_busy;
        writeCount += write_data_array;
        tagCount   += write_tag_array;
        @(posedge clk);
        if (!rstn) begin
            modelFilling = 0;
            reqQ.delete();
            wrQ.delete();
        end else if (!modelFilling) begin
            if (miss) begin
                modelFilling = 1;
                blk = addr & 16'hFFF0;
                reqQ.delete();
                wrQ.delete();
                for (int i = 0; i < 8; i++) begin
                    reqQ.push_back(blk + 16'(2 * i));
                    wrQ.push_back(blk + 16'(2 * i));
                end
            end
        end else begin
            if (reqQ.size() != 0) void'(reqQ.pop_front());
            if (expWr) void'(wrQ.pop_front());
            if (expTag) begin
                modelFilling = 0;
                reqQ.delete();
            end
        end
    endtask

    // gapMode: 0 back-to-back, 1 three-cycle stall after word 2, 2 random gaps.
    task automatic runFill(input logic [15:0] addr, input int lat, input int gapMode,
                           input logic [15:0] pattern, input bit holdMiss, input int resetAt);
        int t[8];
        int k;
        int w;
        bit v;
        t[0] = lat;
        for (int i = 1; i < 8; i++) begin
            int gap;
            gap = (gapMode == 0) ? 0 : (gapMode == 1) ? ((i == 3) ? 3 : 0) : int'($urandom_range(0, 2));
            t[i] = t[i-1] + 1 + gap;
        end
        busyCount = 0; writeCount = 0; tagCount = 0;
        applyStimulus(1'b1, addr, 1'b0, 16'h0, 1'b1);
        k = 0;
        w = 0;
        while (modelFilling && w < 80) begin
            if (w == resetAt) begin
                applyStimulus(1'b1, 16'h0, 1'b1, 16'hDEAD, 1'b0);
                break;
            end
            v = (k < 8) && (w == t[k]);
            applyStimulus(holdMiss, 16'($urandom), v, v ? pattern + 16'(k) : 16'($urandom), 1'b1);
            if (v) k++;
            w++;
        end
        if (modelFilling) checkOutput("fillTimeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; miss_detected = 1'b0; miss_address = '0;
        memory_data_valid = 1'b0; memory_data = '0;

        // Reset held with a miss pending, then a 4-cycle-latency fill at 0x1236.
        applyStimulus(1'b1, 16'h1236, 1'b1, 16'h1111, 1'b0);
        applyStimulus(1'b1, 16'h1236, 1'b1, 16'h2222, 1'b0);
        runFill(16'h1236, 4, 0, 16'hA000, 1'b0, -1);
        checkOutput("busyCycles", busyCount, 32'd13);
        checkOutput("writeCount", writeCount, 32'd8);
        checkOutput("tagCount",   tagCount,   32'd1);

        // Top-of-memory block must not wrap; then the bottom block.
        runFill(16'hFFFE, 2, 0, 16'hB000, 1'b0, -1);
        runFill(16'h0000, 3, 0, 16'hC000, 1'b0, -1);

        // Memory stall after word 2.
        runFill(16'h2468, 1, 1, 16'hD000, 1'b0, -1);
        checkOutput("gapWrites", writeCount, 32'd8);
        checkOutput("gapTags",   tagCount,   32'd1);

        // Reset mid-fill, late returns in IDLE, then a clean fill.
        runFill(16'h7770, 2, 0, 16'hE000, 1'b0, 5);
        writeCount = 0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 16'($urandom), 1'b1);
        checkOutput("lateWrites", writeCount, 32'd0);
        runFill(16'h4000, 4, 0, 16'hF000, 1'b0, -1);
        checkOutput("postRstWrites", writeCount, 32'd8);

        // Miss held through a fill restarts only via a fresh IDLE cycle.
        runFill(16'h0020, 2, 0, 16'h1000, 1'b1, -1);
        runFill(16'h0020, 2, 0, 16'h2000, 1'b0, -1);
        writeCount = 0;
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h5555, 1'b1);
        checkOutput("idleSpurious", writeCount, 32'd0);

        // Randomized fills with occasional held misses, resets and idle noise.
        for (int n = 0; n < 30; n++) begin
            int ra;
            ra = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 10)) : -1;
            runFill(16'($urandom), int'($urandom_range(0, 6)), 2, 16'($urandom),
                    $urandom_range(0, 3) == 0, ra);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                applyStimulus(1'b0, 16'($urandom), 1'($urandom), 16'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
